limb_fetch_unit: RTL and testbench

Instruction fetch sequencer for the Limb 8-bit CPU. It reads the byte-wide program ROM one byte per cycle and assembles variable-length instructions (1–4 bytes, length encoded in the opcode's upper two bits) into a 32-bit instruction register. It presents each complete instruction to the decode/execute stage over a valid/ready handshake and accepts PC redirects from branches, calls and RET. It sits between the program ROM and the decoder, and owns the architectural PC.

---
 rtl/limb_pkg.sv | 29 ++
 rtl/limb_fetch_unit_if.sv | 25 ++
 rtl/limb_sat_counter.sv | 23 ++
 rtl/limb_fetch_unit.sv | 128 ++++++++++++
 tb/tb_limb_fetch_unit.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/limb_pkg.sv
// Shared Limb CPU definitions: fetch FSM states, opcode length field,
// and the opcode constants used by the decoder.
package limb_pkg;

  typedef enum logic [1:0] {
    FETCH_OP   = 2'd0,
    FETCH_MORE = 2'd1,
    HOLD       = 2'd2
  } fetch_state_t;

  // Instruction length lives in the top two bits of the opcode byte.
  localparam int LEN_MSB   = 7;
  localparam int LEN_LSB   = 6;
  localparam int MAX_EXTRA = 3;

  // Opcode constants (length field = bits [7:6], length = field + 1)
  localparam logic [7:0] OP_RET   = 8'h00;
  localparam logic [7:0] OP_NOP   = 8'h01;
  localparam logic [7:0] OP_PUSHI = 8'h41;
  localparam logic [7:0] OP_JMP   = 8'h80;
  localparam logic [7:0] OP_CALL  = 8'h81;
  localparam logic [7:0] OP_LDI32 = 8'hC0;

  // Total instruction length in bytes for a given opcode byte.
  function automatic logic [2:0] insn_len(input logic [7:0] opcode);
    return {1'b0, opcode[LEN_MSB:LEN_LSB]} + 3'd1;
  endfunction

endpackage

// File: rtl/limb_fetch_unit_if.sv
// Fetch-unit bus: program ROM port, instruction handshake to decode,
// and the redirect port from branch/call/RET.
interface limb_fetch_unit_if;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data;
  logic [31:0] ir;
  logic [7:0]  ir_pc;
  logic [2:0]  ir_len;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;

  // Fetch unit side
  modport master (
    output rom_addr, ir, ir_pc, ir_len, ir_valid,
    input  rom_data, ir_ready, redirect_valid, redirect_pc
  );

  // ROM / decoder side
  modport slave (
    input  rom_addr, ir, ir_pc, ir_len, ir_valid,
    output rom_data, ir_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/limb_sat_counter.sv
// Saturating up-counter; sticks at all-ones, cleared only by reset.
module limb_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count increments, holding at the maximum value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_count <= '0;
    else if (i_inc && (r_count != '1))
      r_count <= r_count + WIDTH'(1);
  end

  assign o_count = r_count;

endmodule

// File: rtl/limb_fetch_unit.sv
// Limb instruction fetch sequencer. Reads one ROM byte per cycle,
// assembles 1..4 byte instructions into ir and presents them over a
// valid/ready handshake. Owns the architectural PC.
// Optional feature macro: LIMB_FETCH_STATS_EN adds the fetch_count port
// (saturating count of accepted instructions).
//
//   state      | meaning
//   FETCH_OP   | reading opcode byte at pc
//   FETCH_MORE | reading extra operand bytes, remaining counts down
//   HOLD       | ir complete, ir_valid high, waiting for ir_ready
module limb_fetch_unit
  import limb_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
`ifdef LIMB_FETCH_STATS_EN
  output logic [15:0] fetch_count,
`endif
  limb_fetch_unit_if.master bus
);

  fetch_state_t r_state, w_state_nxt;
  logic [7:0]   r_pc, w_pc_nxt;
  logic [31:0]  r_ir, w_ir_nxt;
  logic [7:0]   r_ir_pc, w_ir_pc_nxt;
  logic [2:0]   r_ir_len, w_ir_len_nxt;
  logic [1:0]   r_remaining, w_remaining_nxt;
  logic [2:0]   w_byte_idx;

  // Index of the extra byte being fetched: 1 for the first operand byte.
  assign w_byte_idx = r_ir_len - {1'b0, r_remaining};

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= FETCH_OP;
    else
      r_state <= w_state_nxt;
  end

  // Next state and datapath; redirect beats fetch_en and sequencing.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_ir_nxt        = r_ir;
    w_ir_pc_nxt     = r_ir_pc;
    w_ir_len_nxt    = r_ir_len;
    w_remaining_nxt = r_remaining;
    if (bus.redirect_valid) begin
      w_pc_nxt    = bus.redirect_pc;
      w_state_nxt = FETCH_OP;
    end else begin
      case (r_state)
        FETCH_OP: begin
          if (fetch_en) begin
            w_ir_nxt        = {bus.rom_data, 24'h0};
            w_ir_pc_nxt     = r_pc;
            w_remaining_nxt = bus.rom_data[LEN_MSB:LEN_LSB];
            w_ir_len_nxt    = insn_len(bus.rom_data);
            w_pc_nxt        = r_pc + 8'd1;
            w_state_nxt     = (bus.rom_data[LEN_MSB:LEN_LSB] == 2'd0) ? HOLD : FETCH_MORE;
          end
        end
        FETCH_MORE: begin
          if (fetch_en) begin
            case (w_byte_idx)
              3'd1:    w_ir_nxt[23:16] = bus.rom_data;
              3'd2:    w_ir_nxt[15:8]  = bus.rom_data;
              3'd3:    w_ir_nxt[7:0]   = bus.rom_data;
              default: w_ir_nxt        = r_ir;
            endcase
            w_pc_nxt        = r_pc + 8'd1;
            w_remaining_nxt = r_remaining - 2'd1;
            if (r_remaining == 2'd1)
              w_state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (bus.ir_ready)
            w_state_nxt = FETCH_OP;
        end
        default: w_state_nxt = FETCH_OP;
      endcase
    end
  end

  // Datapath registers: PC, instruction register and byte countdown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_ir        <= 32'h0;
      r_ir_pc     <= 8'h00;
      r_ir_len    <= 3'd1;
      r_remaining <= 2'd0;
    end else begin
      r_pc        <= w_pc_nxt;
      r_ir        <= w_ir_nxt;
      r_ir_pc     <= w_ir_pc_nxt;
      r_ir_len    <= w_ir_len_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  assign bus.rom_addr = r_pc;
  assign bus.ir       = r_ir;
  assign bus.ir_pc    = r_ir_pc;
  assign bus.ir_len   = r_ir_len;
  assign bus.ir_valid = (r_state == HOLD);

`ifdef LIMB_FETCH_STATS_EN
  logic w_accept;

  // A handshake coinciding with a redirect still counts: that
  // instruction is the branch that caused the redirect.
  assign w_accept = (r_state == HOLD) && bus.ir_ready;

  limb_sat_counter #(.WIDTH(16)) u_fetch_count (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_accept),
    .o_count (fetch_count)
  );
`endif

endmodule

// File: tb/tb_limb_fetch_unit.sv
// Testbench for limb_fetch_unit: ROM model, scoreboard of expected
// instructions, table of single-instruction vectors and hand-written
// sequences for back-pressure, redirect, wrap, fetch_en and reset.
// Compile with +define+LIMB_FETCH_STATS_EN to also check fetch_count.
module tb_limb_fetch_unit;

  typedef struct {
    logic [31:0] ir;
    logic [7:0]  pc;
    logic [2:0]  len;
  } exp_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] bytes;
    logic [2:0]  len;
    logic [31:0] exp_ir;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fetch_en = 1'b1;
  logic [7:0] rom [256];
  logic sat_inc = 1'b0;
  logic [2:0] sat_cnt;
`ifdef LIMB_FETCH_STATS_EN
  logic [15:0] fetch_count;
`endif

  int checks = 0;
  int failures = 0;
  logic [15:0] model_cnt = 16'h0;
  exp_t sb[$];
  vec_t vecs[6];

  limb_fetch_unit_if bus ();

  assign bus.rom_data = rom[bus.rom_addr];

  limb_fetch_unit u_dut (
    .clk      (clk),
    .reset    (reset),
    .fetch_en (fetch_en),
`ifdef LIMB_FETCH_STATS_EN
    .fetch_count (fetch_count),
`endif
    .bus      (bus)
  );

  limb_sat_counter #(.WIDTH(3)) u_sat (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (sat_inc),
    .o_count (sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock: score any handshake occurring at this edge, then step.
  task automatic tick();
    exp_t e;
    if (bus.ir_valid && bus.ir_ready) begin
      if (model_cnt != 16'hFFFF) model_cnt++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_insn actual ir=%h pc=%h required none", bus.ir, bus.ir_pc);
      end else begin
        e = sb.pop_front();
        chk("sb_ir", bus.ir, e.ir);
        chk("sb_ir_pc", {24'h0, bus.ir_pc}, {24'h0, e.pc});
        chk("sb_ir_len", {29'h0, bus.ir_len}, {29'h0, e.len});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] ir, input logic [7:0] pc, input logic [2:0] len);
    exp_t e;
    e.ir = ir; e.pc = pc; e.len = len;
    sb.push_back(e);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.ir_valid && n < 20) begin
      tick();
      n++;
    end
    if (!bus.ir_valid) begin
      checks++;
      failures++;
      $display("FAIL wait_valid_timeout actual=%0d cycles required ir_valid", n);
    end
  endtask

  task automatic redirect(input logic [7:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = pc;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    int lat;
    bus.ir_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 8'h00;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;

    vecs[0] = '{8'h00, 32'h00EE_EEEE, 3'd1, 32'h0000_0000};
    vecs[1] = '{8'h10, 32'hC012_3456, 3'd4, 32'hC012_3456};
    vecs[2] = '{8'h20, 32'h417F_EEEE, 3'd2, 32'h417F_0000};
    vecs[3] = '{8'h30, 32'h85AA_BBEE, 3'd3, 32'h85AA_BB00};
    vecs[4] = '{8'h40, 32'h3FEE_EEEE, 3'd1, 32'h3F00_0000};
    vecs[5] = '{8'h50, 32'hFF01_0203, 3'd4, 32'hFF01_0203};
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 4; j++)
        rom[8'(vecs[i].addr + 8'(j))] = vecs[i].bytes[31 - 8*j -: 8];
    rom[8'h60] = 8'h41; rom[8'h61] = 8'h7F;
    rom[8'h70] = 8'h85; rom[8'h71] = 8'h11; rom[8'h72] = 8'h22;
    rom[8'h80] = 8'h41; rom[8'h81] = 8'h99;
    rom[8'hFE] = 8'hA7; rom[8'hFF] = 8'h5A;

    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_ir", bus.ir, 32'h0);
    chk("rst_ir_pc", {24'h0, bus.ir_pc}, 32'h0);
    chk("rst_ir_len", {29'h0, bus.ir_len}, 32'd1);
    chk("rst_ir_valid", {31'h0, bus.ir_valid}, 32'd0);
    chk("rst_rom_addr", {24'h0, bus.rom_addr}, 32'h0);
`ifdef LIMB_FETCH_STATS_EN
    chk("rst_fetch_count", {16'h0, fetch_count}, 32'h0);
`endif
    reset = 1'b0;

    // Table of single instructions; vector 0 runs straight out of reset.
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        redirect(vecs[i].addr);
        chk("vec_redir_addr", {24'h0, bus.rom_addr}, {24'h0, vecs[i].addr});
        chk("vec_redir_valid", {31'h0, bus.ir_valid}, 32'd0);
      end
      push(vecs[i].exp_ir, vecs[i].addr, vecs[i].len);
      wait_valid(lat);
      chk("vec_latency", lat, {29'h0, vecs[i].len});
      tick();
      chk("vec_next_addr", {24'h0, bus.rom_addr}, {24'h0, 8'(vecs[i].addr + 8'(vecs[i].len))});
      chk("vec_valid_drop", {31'h0, bus.ir_valid}, 32'd0);
    end

    // Back-pressure on a 2-byte PUSHI.
    bus.ir_ready = 1'b0;
    redirect(8'h60);
    push(32'h417F_0000, 8'h60, 3'd2);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      chk("bp_ir", bus.ir, 32'h417F_0000);
      chk("bp_rom_addr", {24'h0, bus.rom_addr}, 32'h62);
      chk("bp_valid", {31'h0, bus.ir_valid}, 32'd1);
      tick();
    end
    bus.ir_ready = 1'b1;
    tick();
    bus.ir_ready = 1'b0;
    chk("bp_valid_drop", {31'h0, bus.ir_valid}, 32'd0);
    chk("bp_single_hs", sb.size(), 32'd0);

    // Redirect during the second byte of a 3-byte instruction.
    bus.ir_ready = 1'b1;
    redirect(8'h70);
    tick();
    chk("mid_in_more", {24'h0, bus.rom_addr}, 32'h71);
    redirect(8'h80);
    chk("mid_rom_addr", {24'h0, bus.rom_addr}, 32'h80);
    chk("mid_valid", {31'h0, bus.ir_valid}, 32'd0);
    push(32'h4199_0000, 8'h80, 3'd2);
    wait_valid(lat);
    chk("mid_latency", lat, 32'd2);
    tick();

    // Handshake and redirect in the same cycle.
    bus.ir_ready = 1'b0;
    redirect(8'h40);
    push(32'h3F00_0000, 8'h40, 3'd1);
    wait_valid(lat);
    bus.ir_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 8'h10;
    tick();
    bus.redirect_valid = 1'b0;
    chk("hsr_valid", {31'h0, bus.ir_valid}, 32'd0);
    chk("hsr_rom_addr", {24'h0, bus.rom_addr}, 32'h10);
    chk("hsr_popped", sb.size(), 32'd0);
    push(32'hC012_3456, 8'h10, 3'd4);
    wait_valid(lat);
    tick();
`ifdef LIMB_FETCH_STATS_EN
    chk("hsr_fetch_count", {16'h0, fetch_count}, {16'h0, model_cnt});
`endif

    // Instruction wrapping FE, FF, 00.
    redirect(8'hFE);
    push(32'hA75A_0000, 8'hFE, 3'd3);
    wait_valid(lat);
    chk("wrap_latency", lat, 32'd3);
    tick();
    chk("wrap_next_addr", {24'h0, bus.rom_addr}, 32'h01);

    // fetch_en low stalls fetch states but not HOLD.
    redirect(8'h50);
    tick();
    fetch_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fen_rom_addr", {24'h0, bus.rom_addr}, 32'h51);
      chk("fen_valid", {31'h0, bus.ir_valid}, 32'd0);
    end
    fetch_en = 1'b1;
    bus.ir_ready = 1'b0;
    push(32'hFF01_0203, 8'h50, 3'd4);
    wait_valid(lat);
    chk("fen_latency", lat, 32'd3);
    fetch_en = 1'b0;
    bus.ir_ready = 1'b1;
    tick();
    chk("fen_hold_hs", sb.size(), 32'd0);
    chk("fen_after_addr", {24'h0, bus.rom_addr}, 32'h54);
    fetch_en = 1'b1;

    // Asynchronous reset in the middle of a 4-byte instruction.
    redirect(8'h10);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("arst_ir", bus.ir, 32'h0);
    chk("arst_ir_len", {29'h0, bus.ir_len}, 32'd1);
    chk("arst_rom_addr", {24'h0, bus.rom_addr}, 32'h0);
    chk("arst_valid", {31'h0, bus.ir_valid}, 32'd0);
`ifdef LIMB_FETCH_STATS_EN
    chk("arst_fetch_count", {16'h0, fetch_count}, 32'h0);
`endif
    model_cnt = 16'h0;
    #1;
    reset = 1'b0;
    push(32'h0000_0000, 8'h00, 3'd1);
    wait_valid(lat);
    chk("arst_latency", lat, 32'd1);
    tick();
`ifdef LIMB_FETCH_STATS_EN
    chk("arst_count_after", {16'h0, fetch_count}, {16'h0, model_cnt});
`endif

    // Saturation of a narrow instance of the counter.
    bus.ir_ready = 1'b0;
    redirect(8'h40);
    sat_inc = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("sat_count", {29'h0, sat_cnt}, (i > 7) ? 32'd7 : i);
    end
    sat_inc = 1'b0;
    tick();
    chk("sat_hold", {29'h0, sat_cnt}, 32'd7);

    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
